// File: rtl/riscv_pkg.sv
// Shared RV32I encodings: opcodes, funct3 codes, data-memory request
// encodings, read-only counter CSR addresses and the ALU operation set.
package riscv_pkg;

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

  localparam logic [2:0] F3_ADD  = 3'b000;
  localparam logic [2:0] F3_SLL  = 3'b001;
  localparam logic [2:0] F3_SLT  = 3'b010;
  localparam logic [2:0] F3_SLTU = 3'b011;
  localparam logic [2:0] F3_XOR  = 3'b100;
  localparam logic [2:0] F3_SR   = 3'b101;
  localparam logic [2:0] F3_OR   = 3'b110;
  localparam logic [2:0] F3_AND  = 3'b111;

  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;
  localparam logic [2:0] F3_BLT  = 3'b100;
  localparam logic [2:0] F3_BGE  = 3'b101;
  localparam logic [2:0] F3_BLTU = 3'b110;
  localparam logic [2:0] F3_BGEU = 3'b111;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;
  localparam logic [2:0] F3_SB  = 3'b000;
  localparam logic [2:0] F3_SH  = 3'b001;
  localparam logic [2:0] F3_SW  = 3'b010;

  localparam logic [2:0] F3_PRIV     = 3'b000;
  localparam logic [2:0] F3_SYS_RSVD = 3'b100;

  localparam logic [1:0] MEM_IDLE  = 2'b00;
  localparam logic [1:0] MEM_READ  = 2'b01;
  localparam logic [1:0] MEM_WRITE = 2'b10;

  localparam logic [11:0] CSR_CYCLE    = 12'hC00;
  localparam logic [11:0] CSR_CYCLEH   = 12'hC80;
  localparam logic [11:0] CSR_INSTRET  = 12'hC02;
  localparam logic [11:0] CSR_INSTRETH = 12'hC82;

  typedef enum logic [3:0] {
    ALU_ADD, ALU_SUB, ALU_SLL, ALU_SLT, ALU_SLTU,
    ALU_XOR, ALU_SRL, ALU_SRA, ALU_OR, ALU_AND
  } alu_op_t;

endpackage

// File: rtl/riscv_alu.sv
// 32-bit integer ALU shared by the OP and OP-IMM instruction groups.
module riscv_alu
  import riscv_pkg::*;
(
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  alu_op_t     op,
  output logic [31:0] result
);

  always_comb begin
    result = '0;
    case (op)
      ALU_ADD:  result = a + b;
      ALU_SUB:  result = a - b;
      ALU_SLL:  result = a << b[4:0];
      ALU_SLT:  result = {31'b0, $signed(a) < $signed(b)};
      ALU_SLTU: result = {31'b0, a < b};
      ALU_XOR:  result = a ^ b;
      ALU_SRL:  result = a >> b[4:0];
      ALU_SRA:  result = $unsigned($signed(a) >>> b[4:0]);
      ALU_OR:   result = a | b;
      ALU_AND:  result = a & b;
      default:  result = '0;
    endcase
  end

endmodule

// File: rtl/riscv_exec_datapath.sv
// Combinational decode/execute/memory-format/writeback for a single-cycle
// RV32I hart; only the cycle and instret counters hold state.
module riscv_exec_datapath
  import riscv_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] pc,
  input  logic [31:0] instr,
  output logic [4:0]  rs1,
  output logic [4:0]  rs2,
  input  logic [31:0] rs1_value,
  input  logic [31:0] rs2_value,
  output logic        jump,
  output logic [31:0] jump_target,
  output logic [1:0]  mem_op,
  output logic [31:0] mem_addr,
  input  logic [31:0] mem_load_data,
  output logic [31:0] mem_store_data,
  output logic [4:0]  rd,
  output logic [31:0] wb
);

  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic [4:0]  rd_field;
  logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;
  logic [31:0] alu_b, alu_result;
  alu_op_t     alu_op;
  logic [31:0] eff_addr, word_addr;
  logic [1:0]  off;
  logic [7:0]  load_byte;
  logic [15:0] load_half;
  logic        load_valid, store_valid, branch_valid, branch_taken, csr_read;
  logic [31:0] load_value, store_word, csr_value;
  logic [63:0] cycle_count, instret_count;

  assign opcode   = instr[6:0];
  assign funct3   = instr[14:12];
  assign rd_field = instr[11:7];
  assign rs1      = instr[19:15];
  assign rs2      = instr[24:20];

  assign imm_i = {{20{instr[31]}}, instr[31:20]};
  assign imm_s = {{20{instr[31]}}, instr[31:25], instr[11:7]};
  assign imm_b = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
  assign imm_u = {instr[31:12], 12'b0};
  assign imm_j = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};

  // instr[30] means SUB only for register-register ops; for OP-IMM it is an immediate bit.
  always_comb begin
    alu_op = ALU_ADD;
    case (funct3)
      F3_ADD:  alu_op = (opcode == OPC_OP && instr[30]) ? ALU_SUB : ALU_ADD;
      F3_SLL:  alu_op = ALU_SLL;
      F3_SLT:  alu_op = ALU_SLT;
      F3_SLTU: alu_op = ALU_SLTU;
      F3_XOR:  alu_op = ALU_XOR;
      F3_SR:   alu_op = instr[30] ? ALU_SRA : ALU_SRL;
      F3_OR:   alu_op = ALU_OR;
      default: alu_op = ALU_AND;
    endcase
  end

  assign alu_b = (opcode == OPC_OP) ? rs2_value : imm_i;

  riscv_alu u_alu (
    .a      (rs1_value),
    .b      (alu_b),
    .op     (alu_op),
    .result (alu_result)
  );

  assign eff_addr  = rs1_value + ((opcode == OPC_STORE) ? imm_s : imm_i);
  assign off       = eff_addr[1:0];
  assign word_addr = {eff_addr[31:2], 2'b00};
  assign load_byte = mem_load_data[{off, 3'b000} +: 8];
  assign load_half = mem_load_data[{off[1], 4'b0000} +: 16];

  always_comb begin
    load_valid = 1'b1;
    load_value = '0;
    case (funct3)
      F3_LB:   load_value = {{24{load_byte[7]}}, load_byte};
      F3_LH:   load_value = {{16{load_half[15]}}, load_half};
      F3_LW:   load_value = mem_load_data;
      F3_LBU:  load_value = {24'b0, load_byte};
      F3_LHU:  load_value = {16'b0, load_half};
      default: load_valid = 1'b0;
    endcase
  end

  // Sub-word stores merge into the word read this same cycle (single-cycle RMW).
  always_comb begin
    store_valid = 1'b1;
    store_word  = mem_load_data;
    case (funct3)
      F3_SB:   store_word[{off, 3'b000} +: 8] = rs2_value[7:0];
      F3_SH:   store_word[{off[1], 4'b0000} +: 16] = rs2_value[15:0];
      F3_SW:   store_word = rs2_value;
      default: store_valid = 1'b0;
    endcase
  end

  always_comb begin
    branch_valid = 1'b1;
    branch_taken = 1'b0;
    case (funct3)
      F3_BEQ:  branch_taken = rs1_value == rs2_value;
      F3_BNE:  branch_taken = rs1_value != rs2_value;
      F3_BLT:  branch_taken = $signed(rs1_value) < $signed(rs2_value);
      F3_BGE:  branch_taken = $signed(rs1_value) >= $signed(rs2_value);
      F3_BLTU: branch_taken = rs1_value < rs2_value;
      F3_BGEU: branch_taken = rs1_value >= rs2_value;
      default: branch_valid = 1'b0;
    endcase
  end

  assign csr_read = (funct3 != F3_PRIV) && (funct3 != F3_SYS_RSVD);

  always_comb begin
    case (instr[31:20])
      CSR_CYCLE:    csr_value = cycle_count[31:0];
      CSR_CYCLEH:   csr_value = cycle_count[63:32];
      CSR_INSTRET:  csr_value = instret_count[31:0];
      CSR_INSTRETH: csr_value = instret_count[63:32];
      default:      csr_value = '0;
    endcase
  end

  always_comb begin
    jump           = 1'b0;
    jump_target    = pc + 32'd4;
    mem_op         = MEM_IDLE;
    mem_addr       = '0;
    mem_store_data = '0;
    rd             = '0;
    wb             = '0;
    case (opcode)
      OPC_LUI: begin
        rd = rd_field;
        wb = imm_u;
      end
      OPC_AUIPC: begin
        rd = rd_field;
        wb = pc + imm_u;
      end
      OPC_JAL: begin
        jump        = 1'b1;
        jump_target = pc + imm_j;
        rd          = rd_field;
        wb          = pc + 32'd4;
      end
      OPC_JALR: begin
        jump        = 1'b1;
        jump_target = (rs1_value + imm_i) & ~32'd1;
        rd          = rd_field;
        wb          = pc + 32'd4;
      end
      OPC_BRANCH: begin
        if (branch_valid) begin
          jump        = branch_taken;
          jump_target = pc + imm_b;
        end
      end
      OPC_OP_IMM, OPC_OP: begin
        rd = rd_field;
        wb = alu_result;
      end
      OPC_LOAD: begin
        if (load_valid) begin
          mem_op   = MEM_READ;
          mem_addr = word_addr;
          rd       = rd_field;
          wb       = load_value;
        end
      end
      OPC_STORE: begin
        if (store_valid) begin
          mem_op         = MEM_WRITE;
          mem_addr       = word_addr;
          mem_store_data = store_word;
        end
      end
      OPC_SYSTEM: begin
        if (csr_read) begin
          rd = rd_field;
          wb = csr_value;
        end
      end
      default: ;
    endcase
  end

  // Every cycle out of reset retires exactly one instruction, so both counters advance together.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cycle_count   <= '0;
      instret_count <= '0;
    end else begin
      cycle_count   <= cycle_count + 64'd1;
      instret_count <= instret_count + 64'd1;
    end
  end

endmodule

// File: tb/tb_riscv_exec_datapath.sv
// Randomized self-checking bench for riscv_exec_datapath against an
// instruction-level reference model, pinned by a few hand-computed vectors.
module tb_riscv_exec_datapath;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] pc = '0, instr = 32'h00000013;
  logic [31:0] rs1_value = '0, rs2_value = '0, mem_load_data = '0;
  logic [4:0]  rs1, rs2, rd;
  logic        jump;
  logic [31:0] jump_target, mem_addr, mem_store_data, wb;
  logic [1:0]  mem_op;

  typedef struct packed {
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic        jump;
    logic [31:0] tgt;
    logic [1:0]  mop;
    logic [31:0] addr;
    logic [31:0] sdata;
    logic [4:0]  rd;
    logic [31:0] wb;
  } exp_t;

  int          checks = 0;
  int          failures = 0;
  logic [63:0] model_count;
  bit          check_en = 1'b0;

  logic [2:0]  br_f3   [6] = '{3'd0, 3'd1, 3'd4, 3'd5, 3'd6, 3'd7};
  logic [2:0]  ld_f3   [5] = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5};
  logic [2:0]  csr_f3  [6] = '{3'd1, 3'd2, 3'd3, 3'd5, 3'd6, 3'd7};
  logic [11:0] csr_adr [4] = '{12'hC00, 12'hC80, 12'hC02, 12'hC82};
  logic [6:0]  bad_opc [4] = '{7'h0B, 7'h2B, 7'h5B, 7'h7F};

  always #5 clk = ~clk;

  riscv_exec_datapath dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .pc             (pc),
    .instr          (instr),
    .rs1            (rs1),
    .rs2            (rs2),
    .rs1_value      (rs1_value),
    .rs2_value      (rs2_value),
    .jump           (jump),
    .jump_target    (jump_target),
    .mem_op         (mem_op),
    .mem_addr       (mem_addr),
    .mem_load_data  (mem_load_data),
    .mem_store_data (mem_store_data),
    .rd             (rd),
    .wb             (wb)
  );

  // Retired-instruction count: one per rising edge out of reset.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) model_count <= '0;
    else        model_count <= model_count + 64'd1;
  end

  function automatic logic [31:0] alu_model(input logic [2:0] f3, input logic alt,
                                            input logic [31:0] x, input logic [31:0] y);
    case (f3)
      3'd0:    return alt ? x - y : x + y;
      3'd1:    return x << y[4:0];
      3'd2:    return ($signed(x) < $signed(y)) ? 32'd1 : 32'd0;
      3'd3:    return (x < y) ? 32'd1 : 32'd0;
      3'd4:    return x ^ y;
      3'd5:    return alt ? 32'($signed(x) >>> y[4:0]) : x >> y[4:0];
      3'd6:    return x | y;
      default: return x & y;
    endcase
  endfunction

  function automatic exp_t model(input logic [31:0] ins, input logic [31:0] p,
                                 input logic [31:0] a, input logic [31:0] b,
                                 input logic [31:0] ld, input logic [63:0] cnt);
    exp_t        e;
    logic [2:0]  f3;
    logic [31:0] ii, si, bi, ji, ea, mask, lane;
    logic [7:0]  bv;
    logic [15:0] hv;
    int          sh;
    f3 = ins[14:12];
    ii = 32'($signed(ins[31:20]));
    si = 32'($signed({ins[31:25], ins[11:7]}));
    bi = 32'($signed({ins[31], ins[7], ins[30:25], ins[11:8], 1'b0}));
    ji = 32'($signed({ins[31], ins[19:12], ins[20], ins[30:21], 1'b0}));
    e = '0;
    e.rs1 = ins[19:15];
    e.rs2 = ins[24:20];
    e.tgt = p + 32'd4;
    case (ins[6:0])
      7'h37: begin e.rd = ins[11:7]; e.wb = {ins[31:12], 12'h000}; end
      7'h17: begin e.rd = ins[11:7]; e.wb = p + {ins[31:12], 12'h000}; end
      7'h6F: begin e.jump = 1'b1; e.tgt = p + ji; e.rd = ins[11:7]; e.wb = p + 32'd4; end
      7'h67: begin e.jump = 1'b1; e.tgt = (a + ii) & 32'hFFFF_FFFE; e.rd = ins[11:7]; e.wb = p + 32'd4; end
      7'h63: begin
        if (f3 != 3'd2 && f3 != 3'd3) begin
          e.tgt = p + bi;
          case (f3)
            3'd0:    e.jump = (a == b);
            3'd1:    e.jump = (a != b);
            3'd4:    e.jump = ($signed(a) < $signed(b));
            3'd5:    e.jump = ($signed(a) >= $signed(b));
            3'd6:    e.jump = (a < b);
            default: e.jump = (a >= b);
          endcase
        end
      end
      7'h13: begin e.rd = ins[11:7]; e.wb = alu_model(f3, (f3 == 3'd5) && ins[30], a, ii); end
      7'h33: begin e.rd = ins[11:7]; e.wb = alu_model(f3, ins[30], a, b); end
      7'h03: begin
        ea = a + ii;
        bv = 8'(ld >> (8 * int'(ea[1:0])));
        hv = 16'(ld >> (16 * int'(ea[1])));
        e.mop = 2'd1;
        e.addr = ea & 32'hFFFF_FFFC;
        e.rd = ins[11:7];
        case (f3)
          3'd0:    e.wb = 32'($signed(bv));
          3'd1:    e.wb = 32'($signed(hv));
          3'd2:    e.wb = ld;
          3'd4:    e.wb = {24'h0, bv};
          default: e.wb = {16'h0, hv};
        endcase
      end
      7'h23: begin
        ea = a + si;
        e.mop = 2'd2;
        e.addr = ea & 32'hFFFF_FFFC;
        case (f3)
          3'd0: begin sh = 8 * int'(ea[1:0]); mask = 32'hFF << sh; lane = (b & 32'hFF) << sh; end
          3'd1: begin sh = 16 * int'(ea[1]); mask = 32'hFFFF << sh; lane = (b & 32'hFFFF) << sh; end
          default: begin mask = 32'hFFFF_FFFF; lane = b; end
        endcase
        e.sdata = (ld & ~mask) | lane;
      end
      7'h73: begin
        if (f3 != 3'd0 && f3 != 3'd4) begin
          e.rd = ins[11:7];
          case (ins[31:20])
            12'hC00, 12'hC02: e.wb = cnt[31:0];
            12'hC80, 12'hC82: e.wb = cnt[63:32];
            default:          e.wb = 32'd0;
          endcase
        end
      end
      default: ;
    endcase
    return e;
  endfunction

  function automatic exp_t sample_dut();
    exp_t s;
    s.rs1 = rs1; s.rs2 = rs2; s.jump = jump; s.tgt = jump_target; s.mop = mem_op;
    s.addr = mem_addr; s.sdata = mem_store_data; s.rd = rd; s.wb = wb;
    return s;
  endfunction

  task automatic check_value(input string name, input logic [31:0] act, input logic [31:0] want);
    checks++;
    if (act !== want) begin
      failures++;
      $display("[TB] FAIL %s actual=%h expected=%h at t=%0t", name, act, want, $time);
    end
  endtask

  task automatic check_output(input string name, input exp_t act, input exp_t want);
    check_value({name, ".rs1"},         32'(act.rs1),  32'(want.rs1));
    check_value({name, ".rs2"},         32'(act.rs2),  32'(want.rs2));
    check_value({name, ".jump"},        32'(act.jump), 32'(want.jump));
    check_value({name, ".jump_target"}, act.tgt,       want.tgt);
    check_value({name, ".mem_op"},      32'(act.mop),  32'(want.mop));
    check_value({name, ".mem_addr"},    act.addr,      want.addr);
    check_value({name, ".store_data"},  act.sdata,     want.sdata);
    check_value({name, ".rd"},          32'(act.rd),   32'(want.rd));
    check_value({name, ".wb"},          act.wb,        want.wb);
  endtask

  task automatic apply_stimulus(input logic [31:0] p, input logic [31:0] ins, input logic [31:0] a,
                                input logic [31:0] b, input logic [31:0] ld);
    pc = p; instr = ins; rs1_value = a; rs2_value = b; mem_load_data = ld;
  endtask

  // Drive a hand-encoded vector and pin both the DUT and the model to the literal answer.
  task automatic directed(input string name, input logic [31:0] p, input logic [31:0] ins,
                          input logic [31:0] a, input logic [31:0] b, input logic [31:0] ld,
                          input exp_t want);
    apply_stimulus(p, ins, a, b, ld);
    #1;
    check_output(name, sample_dut(), want);
    check_output({name, "_model"}, model(ins, p, a, b, ld, model_count), want);
  endtask

  task automatic random_instr(output logic [31:0] ins);
    int cls;
    ins = $urandom;
    cls = $urandom_range(0, 11);
    case (cls)
      0: ins[6:0] = 7'h37;
      1: ins[6:0] = 7'h17;
      2: ins[6:0] = 7'h6F;
      3: begin ins[6:0] = 7'h67; ins[14:12] = 3'd0; end
      4: begin ins[6:0] = 7'h63; ins[14:12] = br_f3[$urandom_range(0, 5)]; end
      5: begin ins[6:0] = 7'h03; ins[14:12] = ld_f3[$urandom_range(0, 4)]; end
      6: begin ins[6:0] = 7'h23; ins[14:12] = 3'($urandom_range(0, 2)); end
      7: begin
        ins[6:0] = 7'h13;
        if (ins[14:12] == 3'd1) ins[31:25] = 7'h00;
        if (ins[14:12] == 3'd5) ins[31:25] = ($urandom_range(0, 1) != 0) ? 7'h20 : 7'h00;
      end
      8: begin
        ins[6:0] = 7'h33;
        ins[31:25] = ((ins[14:12] == 3'd0 || ins[14:12] == 3'd5) && $urandom_range(0, 1) != 0) ? 7'h20 : 7'h00;
      end
      9: begin
        if ($urandom_range(0, 4) == 0) begin
          ins = ($urandom_range(0, 1) != 0) ? 32'h00000073 : 32'h00100073;
        end else begin
          ins[6:0] = 7'h73;
          ins[14:12] = csr_f3[$urandom_range(0, 5)];
          if ($urandom_range(0, 4) != 0) ins[31:20] = csr_adr[$urandom_range(0, 3)];
        end
      end
      10: ins[6:0] = 7'h0F;
      default: ins[6:0] = bad_opc[$urandom_range(0, 3)];
    endcase
  endtask

  // Compare process: outputs are settled by the falling edge after inputs change.
  always @(negedge clk) begin
    if (check_en)
      check_output("rand", sample_dut(),
                   model(instr, pc, rs1_value, rs2_value, mem_load_data, model_count));
  end

  initial begin
    logic [31:0] ins, a, b;
    $display("[TB] riscv_exec_datapath bench start");

    directed("addi", 32'h0, 32'h00500093, 32'h0, 32'h0, 32'h0,
             '{rs1:5'd0, rs2:5'd5, jump:1'b0, tgt:32'h4, mop:2'd0, addr:32'h0, sdata:32'h0, rd:5'd1, wb:32'h5});
    directed("beq_taken", 32'h100, 32'h00208463, 32'd7, 32'd7, 32'h0,
             '{rs1:5'd1, rs2:5'd2, jump:1'b1, tgt:32'h108, mop:2'd0, addr:32'h0, sdata:32'h0, rd:5'd0, wb:32'h0});
    directed("beq_not", 32'h100, 32'h00208463, 32'd7, 32'd8, 32'h0,
             '{rs1:5'd1, rs2:5'd2, jump:1'b0, tgt:32'h108, mop:2'd0, addr:32'h0, sdata:32'h0, rd:5'd0, wb:32'h0});
    directed("jalr", 32'h40, 32'h000080E7, 32'h203, 32'h0, 32'h0,
             '{rs1:5'd1, rs2:5'd0, jump:1'b1, tgt:32'h202, mop:2'd0, addr:32'h0, sdata:32'h0, rd:5'd1, wb:32'h44});
    directed("lb", 32'h0, 32'h00130283, 32'h1000, 32'h0, 32'h123480FF,
             '{rs1:5'd6, rs2:5'd1, jump:1'b0, tgt:32'h4, mop:2'd1, addr:32'h1000, sdata:32'h0, rd:5'd5, wb:32'hFFFFFF80});
    directed("lbu", 32'h0, 32'h00134283, 32'h1000, 32'h0, 32'h123480FF,
             '{rs1:5'd6, rs2:5'd1, jump:1'b0, tgt:32'h4, mop:2'd1, addr:32'h1000, sdata:32'h0, rd:5'd5, wb:32'h00000080});
    directed("sb", 32'h0, 32'h00730123, 32'h1000, 32'hAB, 32'h11223344,
             '{rs1:5'd6, rs2:5'd7, jump:1'b0, tgt:32'h4, mop:2'd2, addr:32'h1000, sdata:32'h11AB3344, rd:5'd0, wb:32'h0});
    directed("unknown_opc", 32'h20, 32'hFFFFFFFF, 32'h5, 32'h6, 32'h7,
             '{rs1:5'd31, rs2:5'd31, jump:1'b0, tgt:32'h24, mop:2'd0, addr:32'h0, sdata:32'h0, rd:5'd0, wb:32'h0});

    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    directed("csr_cycle", 32'h0, 32'hC00021F3, 32'h0, 32'h0, 32'h0,
             '{rs1:5'd0, rs2:5'd0, jump:1'b0, tgt:32'h4, mop:2'd0, addr:32'h0, sdata:32'h0, rd:5'd3, wb:32'h3});
    rst_n = 1'b0;
    #1;
    directed("csr_in_reset", 32'h0, 32'hC00021F3, 32'h0, 32'h0, 32'h0,
             '{rs1:5'd0, rs2:5'd0, jump:1'b0, tgt:32'h4, mop:2'd0, addr:32'h0, sdata:32'h0, rd:5'd3, wb:32'h0});

    @(posedge clk); #1;
    rst_n = 1'b1;
    check_en = 1'b1;
    for (int i = 0; i < 600; i++) begin
      @(posedge clk); #1;
      if (i == 300) rst_n = 1'b0;
      if (i == 303) rst_n = 1'b1;
      random_instr(ins);
      a = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 40)) : $urandom;
      b = ($urandom_range(0, 3) == 0) ? a : $urandom;
      apply_stimulus({$urandom_range(0, 32'h3FFF_FFFF), 2'b00}, ins, a, b, $urandom);
    end
    @(negedge clk);
    check_en = 1'b0;
    #1;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
